// File: rtl/rshift_pkg.sv
// Shared widths, per-stage shift amounts and the payload carried between
// the three registered stages of the right barrel shifter.
package rshift_pkg;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  localparam int SH_S1 = 4;
  localparam int SH_S2 = 2;
  localparam int SH_S3 = 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel_rem;
    logic             fill;
  } payload_t;

  // Right shift by sh with the vacated MSBs taking the fill bit.
  function automatic logic [WIDTH-1:0] shr_fill(input logic [WIDTH-1:0] d,
                                                input logic             fill,
                                                input int unsigned      sh);
    return (d >> sh) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> sh));
  endfunction

endpackage

// File: rtl/rshift_stage.sv
// One valid/ready register stage: conditionally shifts the payload right by
// SHAMT using the latched fill bit, and can load whenever it is empty.
module rshift_stage
  import rshift_pkg::*;
#(
  parameter int SHAMT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     valid_i,
  input  payload_t payload_i,
  output logic     ready_o,
  input  logic     ready_i,
  output logic     valid_o,
  output payload_t payload_o
);

  // SHAMT is a power of two; its log2 names the select bit this stage obeys.
  localparam int SEL_BIT = $clog2(SHAMT);

  logic     valid_q, valid_d;
  payload_t payload_q, payload_d;

  assign ready_o = !valid_q | ready_i;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) begin
        payload_d = payload_i;
        if (payload_i.sel_rem[SEL_BIT]) begin
          payload_d.data = shr_fill(payload_i.data, payload_i.fill, SHAMT);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/right_shift_pipe.sv
// Pipelined 8-bit right barrel shifter: shift by 4, 2, 1 in three registered
// stages with logical/arithmetic fill and valid/ready on both sides.
module right_shift_pipe
  import rshift_pkg::*;
#(
  parameter bit ARITH_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             s2,
  input  logic             s1,
  input  logic             s0,
  input  logic             arith,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] o,
  output logic             out_valid,
  input  logic             out_ready
);

  logic     fill;
  payload_t pl0, pl1, pl2, pl3;
  logic     v1, v2, v3;
  logic     rdy1, rdy2, rdy3;
  logic     unused_tail;

  // Fill is decided once from the original sign bit and travels with the word.
  assign fill = arith & ARITH_EN & a[WIDTH-1];
  assign pl0  = {a, s2, s1, s0, fill};

  rshift_stage #(.SHAMT(SH_S1)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .valid_i(in_valid), .payload_i(pl0), .ready_o(rdy1),
    .ready_i(rdy2), .valid_o(v1), .payload_o(pl1)
  );

  rshift_stage #(.SHAMT(SH_S2)) u_s2 (
    .clk(clk), .rst_n(rst_n),
    .valid_i(v1), .payload_i(pl1), .ready_o(rdy2),
    .ready_i(rdy3), .valid_o(v2), .payload_o(pl2)
  );

  rshift_stage #(.SHAMT(SH_S3)) u_s3 (
    .clk(clk), .rst_n(rst_n),
    .valid_i(v2), .payload_i(pl2), .ready_o(rdy3),
    .ready_i(out_ready), .valid_o(v3), .payload_o(pl3)
  );

  assign in_ready  = rdy1 & rst_n;
  assign o         = pl3.data;
  assign out_valid = v3;

  assign unused_tail = ^{pl3.sel_rem, pl3.fill};

endmodule

// File: tb/tb_right_shift_pipe.sv
// Directed bench for right_shift_pipe: reset, latency, corners, streaming,
// backpressure, bubble collapse and mid-flight reset.
module tb_right_shift_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a;
  logic [2:0] s;
  logic       arith;
  logic       in_valid;
  logic       out_ready;
  logic       in_ready, out_valid;
  logic [7:0] o;
  logic       in_ready_l, out_valid_l;
  logic [7:0] o_l;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  right_shift_pipe #(.ARITH_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .s2(s[2]), .s1(s[1]), .s0(s[0]),
    .arith(arith), .in_valid(in_valid), .in_ready(in_ready),
    .o(o), .out_valid(out_valid), .out_ready(out_ready)
  );

  right_shift_pipe #(.ARITH_EN(1'b0)) dut_log (
    .clk(clk), .rst_n(rst_n), .a(a), .s2(s[2]), .s1(s[1]), .s0(s[0]),
    .arith(arith), .in_valid(in_valid), .in_ready(in_ready_l),
    .o(o_l), .out_valid(out_valid_l), .out_ready(out_ready)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 8'hFF; s = 3'd0; arith = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || o !== 8'h00 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: out_valid=%b o=%h in_ready=%b, want 0 00 0", i, out_valid, o, in_ready);
      end
    end
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b, want 1", in_ready);
    end
    $display("reset: held 3 cycles, released");
  endtask

  task automatic test_single();
    logic [7:0] va [3] = '{8'hB4, 8'hB4, 8'h81};
    logic [2:0] vs [3] = '{3'd3, 3'd3, 3'd6};
    logic       vr [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] ex [3] = '{8'h16, 8'hF6, 8'hFE};
    logic [7:0] exl[3] = '{8'h16, 8'h16, 8'h02};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = va[i]; s = vs[i]; arith = vr[i]; in_valid = 1'b1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL single_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0; a = 8'h00; s = 3'd0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL single_early1[%0d]: out_valid=%b want 0", i, out_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL single_early2[%0d]: out_valid=%b want 0", i, out_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || o !== ex[i] || out_valid_l !== 1'b1 || o_l !== exl[i]) begin
        n_fail++;
        $display("FAIL single_result[%0d]: v=%b o=%h vl=%b ol=%h want 1 %h 1 %h",
                 i, out_valid, o, out_valid_l, o_l, ex[i], exl[i]);
      end
      $display("single: a=%h s=%0d arith=%b -> o=%h o_log=%h", va[i], vs[i], vr[i], o, o_l);
    end
    @(negedge clk);
  endtask

  task automatic test_corners();
    logic [7:0] va [4] = '{8'h5A, 8'h80, 8'h80, 8'h7F};
    logic [2:0] vs [4] = '{3'd0, 3'd7, 3'd7, 3'd7};
    logic       vr [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] ex [4] = '{8'h5A, 8'h01, 8'hFF, 8'h00};
    logic [7:0] exl[4] = '{8'h5A, 8'h01, 8'h01, 8'h00};
    out_ready = 1'b1;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        n_cmp++;
        if (out_valid !== 1'b1 || o !== ex[j-3] || o_l !== exl[j-3]) begin
          n_fail++;
          $display("FAIL corner[%0d]: v=%b o=%h ol=%h want 1 %h %h", j-3, out_valid, o, o_l, ex[j-3], exl[j-3]);
        end
        $display("corner: a=%h s=%0d arith=%b -> o=%h o_log=%h", va[j-3], vs[j-3], vr[j-3], o, o_l);
      end
      if (j < 4) begin
        a = va[j]; s = vs[j]; arith = vr[j]; in_valid = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL corner_in_ready[%0d]: got %b want 1", j, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [7:0] va [4] = '{8'hB4, 8'hF0, 8'h81, 8'hC3};
    logic [2:0] vs [4] = '{3'd1, 3'd4, 3'd2, 3'd5};
    logic       vr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] ex [4] = '{8'h5A, 8'hFF, 8'h20, 8'hFE};
    out_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j < 4) begin
        a = va[j]; s = vs[j]; arith = vr[j]; in_valid = 1'b1;
      end
      n_cmp++;
      if (in_ready !== (j < 3)) begin
        n_fail++;
        $display("FAIL bp_in_ready[%0d]: got %b want %b", j, in_ready, (j < 3));
      end
      if (j >= 3) begin
        n_cmp++;
        if (out_valid !== 1'b1 || o !== ex[0]) begin
          n_fail++;
          $display("FAIL bp_hold[%0d]: v=%b o=%h want 1 %h", j, out_valid, o, ex[0]);
        end
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || o !== ex[0]) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b v=%b o=%h want 1 1 %h", in_ready, out_valid, o, ex[0]);
    end
    $display("backpressure: retire o=%h", o);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || o !== ex[k]) begin
        n_fail++;
        $display("FAIL bp_drain[%0d]: v=%b o=%h want 1 %h", k, out_valid, o, ex[k]);
      end
      $display("backpressure: retire o=%h", o);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_bubble_collapse();
    logic [7:0] va [3] = '{8'h12, 8'h34, 8'hF8};
    logic [2:0] vs [3] = '{3'd0, 3'd4, 3'd3};
    logic [7:0] ex [3] = '{8'h12, 8'h03, 8'hFF};
    out_ready = 1'b0; arith = 1'b1;
    @(negedge clk);
    a = va[0]; s = vs[0]; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int j = 1; j < 3; j++) begin
      a = va[j]; s = vs[j]; in_valid = 1'b1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bubble_in_ready[%0d]: in_ready=%b v=%b want 1 1", j, in_ready, out_valid);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bubble_full: in_ready=%b want 0", in_ready);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || o !== ex[k]) begin
        n_fail++;
        $display("FAIL bubble_drain[%0d]: v=%b o=%h want 1 %h", k, out_valid, o, ex[k]);
      end
      $display("bubble: retire o=%h", o);
      @(negedge clk);
    end
  endtask

  task automatic test_midflight_reset();
    out_ready = 1'b1; arith = 1'b0;
    a = 8'hAA; s = 3'd1; in_valid = 1'b1;
    @(negedge clk);
    a = 8'h55; s = 3'd2;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_flush[%0d]: out_valid=%b o=%h want 0", j, out_valid, o);
      end
      @(negedge clk);
    end
    a = 8'hF0; s = 3'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_next_early: out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || o !== 8'h3C) begin
      n_fail++;
      $display("FAIL rst_next_result: v=%b o=%h want 1 3c", out_valid, o);
    end
    $display("midflight reset: next word o=%h", o);
  endtask

  initial begin
    test_reset();
    test_single();
    test_corners();
    test_backpressure();
    test_bubble_collapse();
    test_midflight_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
